// File: rtl/spi_sched_pkg.sv
// rtl/spi_sched_pkg.sv - shared types and constants for the SPI transaction scheduler
package spi_sched_pkg;

    localparam int BYTE_W = 8;
    localparam int HP_W = 5;

    // Half-period index 16 is the last falling edge; 17 is the HOLD half-period.
    localparam logic [HP_W-1:0] HP_LAST_FALL = 5'd16;
    localparam logic [HP_W-1:0] HP_HOLD = 5'd17;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, HOLD, GAP} state_t;

    function automatic int div_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/spi_byte_shift.sv
// rtl/spi_byte_shift.sv - sclk divider and 8-bit mode-0 shift register (LOAD, SHIFT, HOLD half-periods)
module spi_byte_shift
    import spi_sched_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] tx_byte,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic              hp_tick,
    output logic [HP_W-1:0]   hp,
    output logic              done,
    output logic [BYTE_W-1:0] rx_byte
);

    localparam int CW = div_cnt_w(CLK_DIV);

    logic              active;
    logic [CW-1:0]     div_cnt;
    logic [BYTE_W-1:0] shreg;
    logic [HP_W-1:0]   hp_next;

    assign hp_tick = active && (div_cnt == CW'(CLK_DIV - 1));
    assign hp_next = hp + 1'b1;
    assign done    = hp_tick && (hp == HP_HOLD);
    assign rx_byte = shreg;

    // One register serves both directions: MSB drives mosi, miso enters at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            div_cnt <= '0;
            hp      <= '0;
            shreg   <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            div_cnt <= '0;
            hp      <= '0;
            shreg   <= tx_byte;
            sclk    <= 1'b0;
            mosi    <= tx_byte[BYTE_W-1];
        end else if (hp_tick) begin
            div_cnt <= '0;
            if (hp == HP_HOLD) begin
                active <= 1'b0;
                hp     <= '0;
            end else begin
                hp <= hp_next;
                if (hp_next <= HP_LAST_FALL) begin
                    if (hp_next[0]) begin
                        sclk  <= 1'b1;
                        shreg <= {shreg[BYTE_W-2:0], miso};
                    end else begin
                        sclk <= 1'b0;
                        mosi <= (hp_next == HP_LAST_FALL) ? 1'b0 : shreg[BYTE_W-1];
                    end
                end
            end
        end else if (active) begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// rtl/spi_txn_scheduler.sv - arbitrates requesters onto one SPI bus; SPI_SCHED_RR_EN selects round-robin
module spi_txn_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [BYTE_W*NREQ-1:0] tx_data,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [BYTE_W-1:0]      rx_data,
    output logic                   busy,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic [NREQ-1:0]        cs_n
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CW = div_cnt_w(CLK_DIV);

    state_t            state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  win;
    logic [NREQ-1:0]   win_oh;
    logic [CW-1:0]     gap_cnt;
    logic              gap_last;
    logic              start;
    logic              hp_tick;
    logic              sh_done;
    logic [HP_W-1:0]   hp;
    logic [BYTE_W-1:0] rx_byte;

`ifdef SPI_SCHED_RR_EN
    logic [IDX_W-1:0] ptr;

    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) win = IDX_W'(idx);
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) win = IDX_W'(i);
        end
    end
`endif

    assign win_oh   = NREQ'(1) << win;
    assign gap_last = (gap_cnt == CW'(CLK_DIV - 1));
    // The last GAP cycle doubles as an IDLE cycle so back-to-back grants lose no time.
    assign start    = (|req) && ((state == IDLE) || ((state == GAP) && gap_last));

    spi_byte_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_byte (tx_data[BYTE_W*win +: BYTE_W]),
        .miso    (miso),
        .sclk    (sclk),
        .mosi    (mosi),
        .hp_tick (hp_tick),
        .hp      (hp),
        .done    (sh_done),
        .rx_byte (rx_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            gap_cnt <= '0;
            cs_n    <= '1;
            gnt     <= '0;
            done    <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
`ifdef SPI_SCHED_RR_EN
            ptr     <= '0;
`endif
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                IDLE:  ;
                LOAD:  if (hp_tick) state <= SHIFT;
                SHIFT: if (hp_tick && (hp == HP_LAST_FALL)) state <= HOLD;
                HOLD: begin
                    if (sh_done) begin
                        state       <= GAP;
                        cs_n        <= '1;
                        done[owner] <= 1'b1;
                        rx_data     <= rx_byte;
                        gap_cnt     <= '0;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (start) begin
                state <= LOAD;
                owner <= win;
                gnt   <= win_oh;
                cs_n  <= ~win_oh;
                busy  <= 1'b1;
`ifdef SPI_SCHED_RR_EN
                ptr   <= (win == IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// tb/tb_spi_txn_scheduler.sv - randomized bench against a cycle-offset reference model of the SPI scheduler
module tb_spi_txn_scheduler;

    localparam int NREQ = 4;
    localparam int D = 4;
`ifdef SPI_SCHED_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] tx_data = '0;
    logic              miso = 1'b0;
    logic [NREQ-1:0]   gnt, done, cs_n;
    logic [7:0]        rx_data;
    logic              busy, sclk, mosi;

    spi_txn_scheduler #(.NREQ(NREQ), .CLK_DIV(D)) dut (
        .clk(clk), .rst(rst), .req(req), .tx_data(tx_data), .gnt(gnt), .done(done),
        .rx_data(rx_data), .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int ecyc = 0;

    logic              rst_e;
    logic [NREQ-1:0]   req_e;
    logic [8*NREQ-1:0] tx_e;
    logic              miso_e;

    logic              loop_en = 1'b0;
    logic              miso_rand = 1'b0;
    logic              miso_val = 1'b0;
    logic [NREQ-1:0]   keep = '0;
    logic [NREQ-1:0]   gq[$];

    int         m_act = 0, m_t = 0, m_own = 0, ptr = 0;
    logic [7:0] m_tx = '0, m_rx = '0, m_rxdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, ecyc);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        int idx;
        for (int i = 0; i < NREQ; i++) begin
            idx = i + (RR_EN ? p : 0);
            if (idx >= NREQ) idx = idx - NREQ;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        ecyc++;
        rst_e  = rst;
        req_e  = req;
        tx_e   = tx_data;
        miso_e = miso;
    end

    // Reference: every output is a function of the offset from the last grant edge.
    always @(negedge clk) begin : model
        int rel, m;
        logic [NREQ-1:0] oh, e_gnt, e_done, e_cs;
        logic e_sclk, e_mosi, e_busy;
        if (rst_e) begin
            m_act = 0;
            ptr = 0;
            m_rxdata = '0;
        end else begin
            if (m_act != 0 && (ecyc - m_t) == 19 * D) m_act = 0;
            if (m_act == 0 && req_e != '0) begin
                m_own = pick(req_e, ptr);
                m_act = 1;
                m_t = ecyc;
                m_tx = tx_e[8*m_own +: 8];
                m_rx = '0;
                if (RR_EN) ptr = (m_own + 1) % NREQ;
            end
            if (m_act != 0) begin
                rel = ecyc - m_t;
                if (rel >= D && rel <= 15 * D && (rel % (2 * D)) == D) m_rx = {m_rx[6:0], miso_e};
                if (rel == 18 * D) m_rxdata = m_rx;
            end
        end
        e_gnt = '0; e_done = '0; e_cs = '1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0;
        if (m_act != 0) begin
            rel = ecyc - m_t;
            m = rel / D;
            oh = NREQ'(1) << m_own;
            e_busy = 1'b1;
            if (rel == 0) e_gnt = oh;
            if (rel == 18 * D) e_done = oh;
            if (rel < 18 * D) e_cs = ~oh;
            e_sclk = (m % 2 == 1) && (m <= 15);
            e_mosi = (m <= 15) ? m_tx[7 - m / 2] : 1'b0;
        end
        check_eq("gnt", gnt, e_gnt);
        check_eq("done", done, e_done);
        check_eq("cs_n", cs_n, e_cs);
        check_eq("sclk", sclk, e_sclk);
        check_eq("mosi", mosi, e_mosi);
        check_eq("busy", busy, e_busy);
        check_eq("rx_data", rx_data, m_rxdata);
        check_eq("cs_single", $countones(~cs_n) <= 1, 1);
    end

    task automatic tick();
        @(negedge clk);
        if (gnt != '0) gq.push_back(gnt);
        req = req & ~(gnt & ~keep);
        if (loop_en) miso = mosi;
        else if (miso_rand) miso = 1'($urandom);
        else miso = miso_val;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wait_bit(input bit on_done, input int i, input string tag, output int t);
        t = -1;
        for (int k = 0; k < 400 && t < 0; k++) begin
            tick();
            if ((on_done ? done[i] : gnt[i]) === 1'b1) t = ecyc;
        end
        check_eq(tag, t >= 0, 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int t, td, t3;
        logic [NREQ-1:0] exp_order[5];
        run(3);
        rst = 1'b0;
        run(5);

        tx_data[7:0] = 8'hA5; loop_en = 1'b1; req = 4'b0001;
        wait_bit(1'b0, 0, "single_gnt", t);
        wait_bit(1'b1, 0, "single_done", td);
        check_eq("single_latency", td - t, 72);
        check_eq("single_rx", rx_data, 8'hA5);
        run(10);

        loop_en = 1'b0; miso_val = 1'b1; tx_data[23:16] = 8'h3C; req = 4'b0100;
        wait_bit(1'b0, 2, "r2_gnt", t);
        check_eq("r2_cs_n", cs_n, 4'b1011);
        wait_bit(1'b1, 2, "r2_done", td);
        check_eq("r2_cs_release", cs_n, 4'hF);
        check_eq("r2_rx", rx_data, 8'hFF);
        run(10);

        pulse_rst();
        gq.delete();
        miso_rand = 1'b1; keep = '1; req = '1;
        run(4 * 19 * D + 20);
        keep = '0; req = '0;
        run(100);
        if (RR_EN) exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        else exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        check_eq("hold_count", gq.size() >= 5, 1);
        for (int i = 0; i < 5 && i < gq.size(); i++) check_eq("hold_order", gq[i], exp_order[i]);

        loop_en = 1'b1; req = 4'b0010;
        wait_bit(1'b0, 1, "mid_gnt1", t);
        run(20);
        req[3] = 1'b1;
        wait_bit(1'b0, 3, "mid_gnt3", t3);
        check_eq("mid_gnt3_time", t3 - t, 76);
        run(100);

        req = 4'b0001;
        wait_bit(1'b0, 0, "rst_gnt", t);
        run(29);
        pulse_rst();
        check_eq("rst_cs_n", cs_n, 4'hF);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_busy", busy, 0);
        run(100);
        tx_data[7:0] = 8'h5E; req = 4'b0001;
        wait_bit(1'b1, 0, "post_rst_done", td);
        check_eq("post_rst_rx", rx_data, 8'h5E);
        run(10);

        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NREQ; i++) tx_data[8*i +: 8] = 8'($urandom);
            case ($urandom_range(0, 2))
                0: begin loop_en = 1'b1; miso_rand = 1'b0; end
                1: begin loop_en = 1'b0; miso_rand = 1'b0; miso_val = 1'($urandom); end
                default: begin loop_en = 1'b0; miso_rand = 1'b1; end
            endcase
            keep = ($urandom_range(0, 5) == 0) ? NREQ'($urandom) : '0;
            req = req | NREQ'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                run($urandom_range(0, 80));
                pulse_rst();
            end
            run($urandom_range(1, 150));
        end
        keep = '0; req = '0;
        run(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
